// File: rtl/scratchpad_mem.sv
// Parametrised synchronous scratchpad: N_RD independent read ports with a READ_LAT-deep valid
// pipeline, byte-swapping write port, and hardware zero-fill of every word after reset.
module scratchpad_mem #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned READ_LAT = 1,
   parameter int unsigned N_RD     = 2,
   parameter int unsigned WR_FIRST = 0
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic                     io_init_done,
   input  logic                     io_write_en,
   input  logic                     io_write_swap,
   input  logic [ADDR_W-1:0]        io_write_addr,
   input  logic [DATA_W-1:0]        io_write_data,
   input  logic [N_RD-1:0]          io_rd_en,
   input  logic [N_RD*ADDR_W-1:0]   io_rd_addr,
   output logic [N_RD*DATA_W-1:0]   io_rd_data,
   output logic [N_RD-1:0]          io_rd_valid,
   output logic                     io_err
);

   localparam int unsigned      NBytes  = DATA_W / 8;
   localparam int unsigned      IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DepthA  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IdxW-1:0]  LastIdx = IdxW'(DEPTH - 1);

   typedef enum logic [0:0] {StInit, StReady} state_e;

   state_e                              state_q, state_d;
   logic [IdxW-1:0]                     cnt_q;
   logic                                err_q, err_d;
   logic [DATA_W-1:0]                   mem [DEPTH];

   logic                                ready;
   logic                                wr_in_range, wr_ok;
   logic [DATA_W-1:0]                   wr_swapped, wr_word;
   logic [N_RD-1:0][ADDR_W-1:0]         rd_addr;
   logic [N_RD-1:0]                     rd_in_range;
   logic [N_RD-1:0]                     rd_vld_d;
   logic [N_RD-1:0][DATA_W-1:0]         rd_dat_d;

   logic [READ_LAT-1:0][N_RD-1:0]              vld_q, vld_in;
   logic [READ_LAT-1:0][N_RD-1:0][DATA_W-1:0]  dat_q, dat_in;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StInit;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StInit:  if (cnt_q == LastIdx) state_d = StReady;
         StReady: state_d = StReady;
         default: state_d = StInit;
      endcase
   end

   // Output logic
   always_comb begin
      io_init_done = (state_q == StReady);
   end

   assign ready = io_init_done;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (state_q == StInit) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   always_comb begin
      wr_swapped = '0;
      for (int b = 0; b < NBytes; b++) begin
         wr_swapped[b*8 +: 8] = io_write_data[(NBytes-1-b)*8 +: 8];
      end
   end

   assign wr_word     = io_write_swap ? wr_swapped : io_write_data;
   assign wr_in_range = {1'b0, io_write_addr} < DepthA;
   assign wr_ok       = ready & io_write_en & wr_in_range;

   // Memory array carries no reset; INIT zero-fills it one word per cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state_q == StInit) begin
            mem[cnt_q] <= '0;
         end else if (wr_ok) begin
            mem[io_write_addr[IdxW-1:0]] <= wr_word;
         end
      end
   end

   assign rd_addr = io_rd_addr;

   // Pipeline stage 0: launch reads; out-of-range reads return zero but still signal valid.
   always_comb begin
      rd_in_range = '0;
      rd_vld_d    = '0;
      rd_dat_d    = '0;
      for (int p = 0; p < N_RD; p++) begin
         rd_in_range[p] = {1'b0, rd_addr[p]} < DepthA;
         rd_vld_d[p]    = ready & io_rd_en[p];
         if (rd_vld_d[p] && rd_in_range[p]) begin
            rd_dat_d[p] = mem[rd_addr[p][IdxW-1:0]];
            if (WR_FIRST != 0 && wr_ok && io_write_addr == rd_addr[p]) begin
               rd_dat_d[p] = wr_word;
            end
         end
      end
   end

   always_comb begin
      err_d = err_q;
      if (state_q == StInit && |io_rd_en) err_d = 1'b1;
      if (ready && io_write_en && !wr_in_range) err_d = 1'b1;
      if (ready && |(io_rd_en & ~rd_in_range)) err_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   always_comb begin
      vld_in    = '0;
      dat_in    = '0;
      vld_in[0] = rd_vld_d;
      dat_in[0] = rd_dat_d;
      for (int s = 1; s < READ_LAT; s++) begin
         vld_in[s] = vld_q[s-1];
         dat_in[s] = dat_q[s-1];
      end
   end

   // Data registers load only with a valid word so idle ports hold their last value.
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q <= '0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_in;
         for (int s = 0; s < READ_LAT; s++) begin
            for (int p = 0; p < N_RD; p++) begin
               if (vld_in[s][p]) dat_q[s][p] <= dat_in[s][p];
            end
         end
      end
   end

   assign io_rd_valid = vld_q[READ_LAT-1];
   assign io_rd_data  = dat_q[READ_LAT-1];
   assign io_err      = err_q;

endmodule
